rom_programmer: RTL and testbench
=================================

ROM_PROGRAMMER -- requirements
Module: rom_programmer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, PROM data bits (8 for 556PT5, 4 for 556PT4).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 9, PROM address bits (9 for PT5, 8 for PT4).
REQ-003 SHALL have parameter SETUP_CYCLES, default 4, address/data setup time before each fuse pulse.
REQ-004 SHALL have parameter PULSE_CYCLES, default 16, programming pulse width.
REQ-005 SHALL have parameter RECOVER_CYCLES, default 8, hold/cool-down after each pulse.
REQ-006 SHALL have parameter MAX_RETRIES, default 3, re-pulse passes allowed after failed verify.
REQ-007 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-010 SHALL have port address_in  input  ADDRESS_WIDTH  target cell, latched on accepted start.
REQ-011 SHALL have port data_in  input  DATA_WIDTH  bits to blow (1 = program), latched on accepted start.
REQ-012 SHALL have port data_line_in  input  DATA_WIDTH  chip outputs for readback.
REQ-013 SHALL have port operation  output  4  V1..V4 control (bit0 = V1 ... bit3 = V4).
REQ-014 SHALL have port address_line  output  ADDRESS_WIDTH  chip address.
REQ-015 SHALL have port data_line  output  DATA_WIDTH  one-hot select of the bit being pulsed, else 0.
REQ-016 SHALL have port busy  output  1  high from accepted start until done.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port error  output  1  result flag, valid with done, held until next accepted start.

Function
REQ-019 SHALL use states IDLE, SETUP, PULSE, RECOVER, VERIFY, DONE; operation = 4'b0000 in IDLE/DONE, 4'b0011 in PULSE, 4'b1100 in SETUP/RECOVER/VERIFY.
REQ-020 SHALL, in IDLE with start=1, latch address_in/data_in, set pending mask = data_in, clear error and retry count, assert busy next cycle.
REQ-021 SHALL select lowest set bit of pending mask; if mask is zero, go to VERIFY (macro on) or DONE (macro off).
REQ-022 SHALL hold SETUP exactly SETUP_CYCLES with data_line = one-hot of selected bit, then PULSE exactly PULSE_CYCLES, then RECOVER exactly RECOVER_CYCLES, data_line = 0 in RECOVER.
REQ-023 SHALL clear the selected bit from pending mask at end of RECOVER and return to REQ-021 selection.
REQ-024 SHALL keep address_line constant at latched address for the whole operation.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL, in DONE, pulse done for one cycle, drop busy in the same cycle, return to IDLE next cycle.
REQ-027 SHALL use cycle counters wide enough for max(SETUP_CYCLES, PULSE_CYCLES, RECOVER_CYCLES); a value of 0 SHALL be treated as 1.
REQ-028 SHALL address the full 2^ADDRESS_WIDTH range; no wrap or clamping of address_in.

Reset
REQ-029 SHALL, with reset=1 at a clock edge, enter IDLE and drive operation=0, data_line=0, address_line=0, busy=0, done=0, error=0, clear counters and masks.
REQ-030 SHALL abort any operation in progress, including mid-PULSE, on reset, with operation=0 on the next edge.
REQ-031 SHALL let reset take priority over start in the same cycle.

Configuration
REQ-032 SHALL use macro ROM_PROGRAMMER_VERIFY_EN to include readback verification.
REQ-033 SHALL, with the macro defined, hold VERIFY SETUP_CYCLES then sample data_line_in: extra bits (sample & ~data) set -> error=1, DONE; missing bits (data & ~sample) zero -> error=0, DONE; missing nonzero and retries < MAX_RETRIES -> pending mask = missing, retries+1, resume REQ-021; otherwise error=1, DONE.
REQ-034 SHALL, without the macro, omit VERIFY entirely, never assert error, and go to DONE after last RECOVER.

Verification
REQ-035 SHALL test: start, address_in=9'h005, data_in=8'h81 -> two SETUP/PULSE/RECOVER passes with data_line 8'h01 then 8'h80, address_line=9'h005, one done pulse.
REQ-036 SHALL test: data_in=8'h00 -> no PULSE cycles, operation never 4'b0011, done after VERIFY (or immediately without macro), error=0.
REQ-037 SHALL test (macro on): data_in=8'h0F, readback 8'h07 for first verify then 8'h0F -> one retry pulsing only bit 3, done with error=0.
REQ-038 SHALL test (macro on): readback stuck at 8'h00, data_in=8'h01 -> exactly 1+MAX_RETRIES=4 pulses, done with error=1.
REQ-039 SHALL test: reset asserted in 5th PULSE cycle -> operation=0, busy=0 next edge; new start afterwards completes normally.
REQ-040 SHALL test: start held high through operation and after done -> exactly one operation per IDLE acceptance, start ignored while busy.

Source files
------------

// File: rtl/rom_programmer.sv
// rom_programmer: blows 556PT4/PT5 fuse cells one bit at a time with timed setup/pulse/recover phases.
// Optional readback verify with re-pulse retries is built when ROM_PROGRAMMER_VERIFY_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; latches address/data on accept
// SETUP   | address and one-hot data select settle before the pulse (V3/V4)
// PULSE   | programming pulse on the selected bit (V1/V2)
// RECOVER | cool-down after the pulse, data select released
// VERIFY  | readback settle, then compare chip outputs against requested data
// DONE    | one-cycle completion strobe, busy already low
module rom_programmer #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 9,
    parameter int SETUP_CYCLES   = 4,
    parameter int PULSE_CYCLES   = 16,
    parameter int RECOVER_CYCLES = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0]    data_line,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int SETUP_N   = (SETUP_CYCLES   < 1) ? 1 : SETUP_CYCLES;
    localparam int PULSE_N   = (PULSE_CYCLES   < 1) ? 1 : PULSE_CYCLES;
    localparam int RECOVER_N = (RECOVER_CYCLES < 1) ? 1 : RECOVER_CYCLES;
    localparam int MAX_N     = (SETUP_N > PULSE_N)
                               ? ((SETUP_N > RECOVER_N) ? SETUP_N : RECOVER_N)
                               : ((PULSE_N > RECOVER_N) ? PULSE_N : RECOVER_N);
    localparam int CNT_W     = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_N - 1);
    localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_N - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [3:0] OP_OFF    = 4'b0000;
    localparam logic [3:0] OP_PROG   = 4'b0011;
    localparam logic [3:0] OP_SELECT = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_RECOVER,
        ST_VERIFY,
        ST_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    mask_q, mask_d;
    logic [DATA_WIDTH-1:0]    sel_q, sel_d;
    logic                     cnt_tc;
    logic                     do_select;
    logic [DATA_WIDTH-1:0]    sel_src;

`ifdef ROM_PROGRAMMER_VERIFY_EN
    localparam int RTY_W = (MAX_RETRIES >= 1) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRIES);
    localparam logic [RTY_W-1:0] RETRY_ONE = RTY_W'(1);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [RTY_W-1:0]      retry_q, retry_d;
    logic                  error_q, error_d;
    logic [DATA_WIDTH-1:0] rb_extra;
    logic [DATA_WIDTH-1:0] rb_missing;

    assign rb_extra   = data_line_in & ~data_q;
    assign rb_missing = data_q & ~data_line_in;
    assign error      = error_q;
`else
    logic unused_readback;

    assign unused_readback = ^data_line_in;
    assign error           = 1'b0;
`endif

    // Isolates the lowest set bit: fuses are blown LSB first.
    function automatic logic [DATA_WIDTH-1:0] lowest_bit(input logic [DATA_WIDTH-1:0] m);
        return m & (~m + DATA_WIDTH'(1));
    endfunction

    assign cnt_tc = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            sel_q   <= '0;
`ifdef ROM_PROGRAMMER_VERIFY_EN
            data_q  <= '0;
            retry_q <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
`ifdef ROM_PROGRAMMER_VERIFY_EN
            data_q  <= data_d;
            retry_q <= retry_d;
            error_q <= error_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        sel_d     = sel_q;
        do_select = 1'b0;
        sel_src   = mask_q;
`ifdef ROM_PROGRAMMER_VERIFY_EN
        data_d    = data_q;
        retry_d   = retry_q;
        error_d   = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d    = address_in;
                    do_select = 1'b1;
                    sel_src   = data_in;
`ifdef ROM_PROGRAMMER_VERIFY_EN
                    data_d    = data_in;
                    retry_d   = '0;
                    error_d   = 1'b0;
`endif
                end
            end
            ST_SETUP: begin
                if (cnt_tc) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (cnt_tc) begin
                    state_d = ST_RECOVER;
                    cnt_d   = RECOVER_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RECOVER: begin
                if (cnt_tc) begin
                    do_select = 1'b1;
                    sel_src   = mask_q & ~sel_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef ROM_PROGRAMMER_VERIFY_EN
            ST_VERIFY: begin
                if (cnt_tc) begin
                    // A cell reading 1 that was never requested cannot be undone.
                    if (rb_extra != '0) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (rb_missing == '0) begin
                        state_d = ST_DONE;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d   = retry_q + RETRY_ONE;
                        do_select = 1'b1;
                        sel_src   = rb_missing;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_select) begin
            mask_d = sel_src;
            sel_d  = lowest_bit(sel_src);
            if (sel_src != '0) begin
                state_d = ST_SETUP;
                cnt_d   = SETUP_LD;
            end else begin
`ifdef ROM_PROGRAMMER_VERIFY_EN
                state_d = ST_VERIFY;
                cnt_d   = SETUP_LD;
`else
                state_d = ST_DONE;
`endif
            end
        end
    end

    always_comb begin
        operation = OP_OFF;
        data_line = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_SETUP: begin
                operation = OP_SELECT;
                data_line = sel_q;
                busy      = 1'b1;
            end
            ST_PULSE: begin
                operation = OP_PROG;
                data_line = sel_q;
                busy      = 1'b1;
            end
            ST_RECOVER: begin
                operation = OP_SELECT;
                busy      = 1'b1;
            end
`ifdef ROM_PROGRAMMER_VERIFY_EN
            ST_VERIFY: begin
                operation = OP_SELECT;
                busy      = 1'b1;
            end
`endif
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign address_line = addr_q;

endmodule

// File: tb/tb_rom_programmer.sv
// Testbench for rom_programmer: emulated PROM with per-bit fuse behaviour, checked cycle by cycle
// against an expected trace derived from the programming rules.
`timescale 1ns/1ps
module tb_rom_programmer;

    localparam int DW = 8;
    localparam int AW = 9;
    localparam int S  = 4;
    localparam int P  = 16;
    localparam int R  = 8;
    localparam int MR = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] address_in;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_line_in;
    logic [3:0]    operation;
    logic [AW-1:0] address_line;
    logic [DW-1:0] data_line;
    logic          busy;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    rom_programmer #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .SETUP_CYCLES  (S),
        .PULSE_CYCLES  (P),
        .RECOVER_CYCLES(R),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .address_in  (address_in),
        .data_in     (data_in),
        .data_line_in(data_line_in),
        .operation   (operation),
        .address_line(address_line),
        .data_line   (data_line),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    int checks = 0;
    int errors = 0;

    // Emulated chip: a bit reads 1 if pre-blown, or once it has received need[b] full pulses
    // (need[b] == 0 means the fuse never blows).
    int            need[DW];
    logic [DW-1:0] blown_init;
    int            pulse_cyc[DW] = '{default: 0};
    int            base_cyc[DW]  = '{default: 0};

    always @(posedge clk)
        for (int b = 0; b < DW; b++)
            if (operation == 4'b0011 && data_line[b]) pulse_cyc[b] <= pulse_cyc[b] + 1;

    always_comb begin
        data_line_in = blown_init;
        for (int b = 0; b < DW; b++)
            if (need[b] > 0 && (pulse_cyc[b] - base_cyc[b]) >= need[b] * P) data_line_in[b] = 1'b1;
    end

    typedef struct packed {
        logic [3:0]    op;
        logic [DW-1:0] dl;
        logic          busy;
        logic          done;
        logic          err;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_n(input int n, input logic [3:0] op, input logic [DW-1:0] dl,
                          input logic bz, input logic dn, input logic er);
        exp_t e;
        e.op = op; e.dl = dl; e.busy = bz; e.done = dn; e.err = er;
        for (int k = 0; k < n; k++) exp_q.push_back(e);
    endtask

    task automatic set_chip(input int n, input logic [DW-1:0] pre);
        for (int b = 0; b < DW; b++) need[b] = n;
        blown_init = pre;
    endtask

    // Expected observable trace of one operation, one entry per clock after acceptance.
    task automatic build_trace(input logic [DW-1:0] d);
        logic [DW-1:0] pending;
        logic [DW-1:0] oh;
        int            pulses[DW];
        bit            fin;
        logic          er;
`ifdef ROM_PROGRAMMER_VERIFY_EN
        logic [DW-1:0] blown;
        logic [DW-1:0] extra;
        logic [DW-1:0] missing;
        int            retries;
        retries = 0;
`endif
        exp_q.delete();
        pending = d;
        fin     = 1'b0;
        er      = 1'b0;
        for (int b = 0; b < DW; b++) pulses[b] = 0;
        while (!fin) begin
            for (int b = 0; b < DW; b++) begin
                if (pending[b]) begin
                    oh = '0;
                    oh[b] = 1'b1;
                    push_n(S, 4'b1100, oh, 1'b1, 1'b0, 1'b0);
                    push_n(P, 4'b0011, oh, 1'b1, 1'b0, 1'b0);
                    push_n(R, 4'b1100, '0, 1'b1, 1'b0, 1'b0);
                    pulses[b]++;
                end
            end
`ifdef ROM_PROGRAMMER_VERIFY_EN
            push_n(S, 4'b1100, '0, 1'b1, 1'b0, 1'b0);
            blown = blown_init;
            for (int b = 0; b < DW; b++)
                if (need[b] > 0 && pulses[b] >= need[b]) blown[b] = 1'b1;
            extra   = blown & ~d;
            missing = d & ~blown;
            if (extra != '0) begin
                er = 1'b1; fin = 1'b1;
            end else if (missing == '0) begin
                fin = 1'b1;
            end else if (retries < MR) begin
                retries++;
                pending = missing;
            end else begin
                er = 1'b1; fin = 1'b1;
            end
`else
            fin = 1'b1;
`endif
        end
        push_n(1, 4'b0000, '0, 1'b0, 1'b1, er);
    endtask

    // Called at a negedge. abort_at >= 0 asserts reset after that trace cycle.
    task automatic run_op(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit pre_started, input bit hold,
                          input logic [AW-1:0] na, input logic [DW-1:0] nd, input int abort_at);
        exp_t got;
        logic last_err;
        for (int b = 0; b < DW; b++) base_cyc[b] = pulse_cyc[b];
        build_trace(d);
        last_err = exp_q[exp_q.size()-1].err;
        if (!pre_started) begin
            address_in = a;
            data_in    = d;
            start      = 1'b1;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            got.op = operation; got.dl = data_line; got.busy = busy; got.done = done; got.err = error;
            checks++;
            if (got !== exp_q[i] || address_line !== a) begin
                errors++;
                $display("FAIL %s cycle %0d: got op=%b dl=%h busy=%b done=%b err=%b addr=%h, expected op=%b dl=%h busy=%b done=%b err=%b addr=%h",
                         name, i, got.op, got.dl, got.busy, got.done, got.err, address_line,
                         exp_q[i].op, exp_q[i].dl, exp_q[i].busy, exp_q[i].done, exp_q[i].err, a);
            end
            if (!hold) start = 1'b0;
            if (i == exp_q.size() - 1) begin
                address_in = na;
                data_in    = nd;
            end else begin
                address_in = AW'($urandom);
                data_in    = DW'($urandom);
            end
            if (i == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                checks++;
                if ({operation, data_line, address_line, busy, done, error} !== '0) begin
                    errors++;
                    $display("FAIL %s abort: got op=%b dl=%h addr=%h busy=%b done=%b err=%b, expected all zero",
                             name, operation, data_line, address_line, busy, done, error);
                end
                reset = 1'b0;
                return;
            end
        end
        @(negedge clk);
        checks++;
        if (operation !== 4'b0000 || data_line !== '0 || busy !== 1'b0 || done !== 1'b0 || error !== last_err) begin
            errors++;
            $display("FAIL %s idle_after: got op=%b dl=%h busy=%b done=%b err=%b, expected op=0000 dl=0 busy=0 done=0 err=%b",
                     name, operation, data_line, busy, done, error, last_err);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b1;
        address_in = AW'($urandom);
        data_in    = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({operation, data_line, address_line, busy, done, error} !== '0) begin
                errors++;
                $display("FAIL reset_state: got op=%b dl=%h addr=%h busy=%b done=%b err=%b, expected all zero",
                         operation, data_line, address_line, busy, done, error);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || operation !== 4'b0000) begin
            errors++;
            $display("FAIL reset_priority: got busy=%b op=%b, expected busy=0 op=0000", busy, operation);
        end
    endtask

    task automatic test_two_bits();
        set_chip(1, '0);
        run_op("two_bits", 9'h005, 8'h81, 1'b0, 1'b0, '0, '0, -1);
    endtask

    task automatic test_zero_data();
        set_chip(1, '0);
        run_op("zero_data", AW'($urandom), 8'h00, 1'b0, 1'b0, '0, '0, -1);
    endtask

    task automatic test_retry();
        set_chip(1, '0);
        need[3] = 2;
        run_op("retry_bit3", 9'h0A5, 8'h0F, 1'b0, 1'b0, '0, '0, -1);
    endtask

    task automatic test_stuck();
        int seen;
        int want;
        set_chip(0, '0);
        run_op("stuck_low", 9'h1FF, 8'h01, 1'b0, 1'b0, '0, '0, -1);
        seen = pulse_cyc[0] - base_cyc[0];
`ifdef ROM_PROGRAMMER_VERIFY_EN
        want = (1 + MR) * P;
`else
        want = P;
`endif
        checks++;
        if (seen !== want) begin
            errors++;
            $display("FAIL stuck_pulse_cycles: got %0d, expected %0d", seen, want);
        end
    endtask

    task automatic test_reset_mid_pulse();
        set_chip(1, '0);
        run_op("abort_pulse", 9'h123, 8'h81, 1'b0, 1'b0, '0, '0, S + 4);
        run_op("after_abort", 9'h0C3, 8'h12, 1'b0, 1'b0, '0, '0, -1);
    endtask

    task automatic test_back_to_back();
        set_chip(1, '0);
        run_op("b2b_first", 9'h155, 8'h24, 1'b0, 1'b1, 9'h0AA, 8'h41, -1);
        run_op("b2b_second", 9'h0AA, 8'h41, 1'b1, 1'b0, '0, '0, -1);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] pre;
        for (int n = 0; n < 15; n++) begin
            for (int b = 0; b < DW; b++)
                need[b] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
            pre = '0;
            if ($urandom_range(0, 5) == 0) pre[$urandom_range(0, DW-1)] = 1'b1;
            blown_init = pre;
            a = (n == 0) ? '0 : (n == 1) ? '1 : AW'($urandom);
            d = DW'($urandom);
            run_op($sformatf("random_%0d", n), a, d, 1'b0, 1'b0, '0, '0, -1);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        address_in = '0;
        data_in    = '0;
        set_chip(1, '0);
        test_reset();
        test_two_bits();
        test_zero_data();
        test_retry();
        test_stuck();
        test_reset_mid_pulse();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
